// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// The FSM state encoding lives here so the top and any future peers agree on it.
package uart_tx_pkg;

  localparam int UART_WIDTH_DEF   = 8;
  localparam int UART_NREQ_DEF    = 4;
  localparam int UART_TMO_CYC_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_e;

  // Index of the requester after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin selector: the first asserted request at or after ptr wins.
// Produces a one-hot grant, the winning index, and a hit flag.
module rr_arbiter
  import uart_tx_pkg::*;
#(
  parameter  int NREQ = UART_NREQ_DEF,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            hit
);

  logic [IW-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    pos = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = IW'((32'(ptr) + 32'(k)) % 32'(NREQ));
      if (!hit && req[pos]) begin
        hit      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART transmitter among NREQ requesters.
// Optional Busy-rise watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for a request while the transmitter is free
// ISSUE     | one-cycle Data_valid launch of the latched frame
// WAIT_BUSY | waiting for the transmitter to raise Busy
// WAIT_DONE | waiting for Busy to fall at the end of the frame
module uart_tx_sched
  import uart_tx_pkg::*;
#(
  parameter  int WIDTH   = UART_WIDTH_DEF,
  parameter  int NREQ    = UART_NREQ_DEF,
  parameter  int TMO_CYC = UART_TMO_CYC_DEF,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_par_en,
  input  logic [NREQ-1:0]       req_par_type,
  output logic [NREQ-1:0]       req_ready,
  output logic                  Data_valid,
  output logic [WIDTH-1:0]      P_data,
  output logic                  Par_en,
  output logic                  Par_type,
  input  logic                  Busy,
  output logic [IW-1:0]         grant_id,
  output logic                  sched_busy,
  output logic                  tmo_err
);

  sched_state_e state, state_nxt;

  logic [IW-1:0]    rr_ptr;
  logic [NREQ-1:0]  arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_hit;
  logic             grant_take;
  logic             tmo_fire;
  logic [WIDTH-1:0] req_data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_data_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .hit (arb_hit)
  );

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_flag;
  logic          tmo_expired;

  assign tmo_expired = (tmo_cnt == '0);
`else
  logic tmo_expired;

  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    Data_valid = 1'b0;
    tmo_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (arb_hit && !Busy) begin
          req_ready = arb_gnt;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        Data_valid = 1'b1;
        state_nxt  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (Busy) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_expired) begin
          tmo_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!Busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing may be accepted or launched while reset is being applied.
    if (rst) begin
      req_ready  = '0;
      Data_valid = 1'b0;
    end
  end

  assign grant_take = |req_ready;
  assign sched_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      P_data   <= '0;
      Par_en   <= 1'b0;
      Par_type <= 1'b0;
      grant_id <= '0;
    end else begin
      state <= state_nxt;
      if (grant_take) begin
        P_data   <= req_data_arr[arb_idx];
        Par_en   <= req_par_en[arb_idx];
        Par_type <= req_par_type[arb_idx];
        grant_id <= arb_idx;
        rr_ptr   <= IW'(rr_next(32'(arb_idx), 32'(NREQ)));
      end
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  // Down-counter loaded during ISSUE so it expires on the TMO_CYC-th WAIT_BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        tmo_cnt <= TW'(TMO_CYC - 1);
      end else if (state == WAIT_BUSY && !tmo_expired) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (tmo_fire) tmo_flag <= 1'b1;
    end
  end

  assign tmo_err = tmo_flag;
`else
  assign tmo_err = 1'b0;
`endif

endmodule
